// File: rtl/instr_decode_seq.sv
// Instruction fetch/decode sequencer for the register-file/ALU datapath.
// Fetches 16-bit words over a req/valid handshake. Each word is decoded and the
// datapath controls are then driven for exactly one execute cycle.
// Instruction word: [15:8] ALU opcode, [7:4] Rdest, [3:0] Rsrc or imm4.
// Ports:
//   clock, Reset      rising-edge clock, asynchronous active-low reset
//   run               level; 1 lets the sequencer fetch, 0 stops at the next instruction boundary
//   imem_req/addr     fetch request (held until imem_valid) and fetch address (= pc)
//   imem_valid/data   returned instruction word
//   reg_enable        one-hot register write enable, high only during EXEC
//   reg_a_sel/b_sel   A/B read-mux selects
//   alu_op, imm       ALU opcode and 4-bit immediate
//   flag_enable       flag register capture enable, high only during EXEC
//   pc                program counter
//   halted            sticky; an illegal opcode was seen
//   busy              high in FETCH, DECODE and EXEC
module instr_decode_seq #(
  parameter int unsigned PC_W = 8
) (
  input  logic            clock,
  input  logic            Reset,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [15:0]     imem_data,
  output logic [15:0]     reg_enable,
  output logic [3:0]      reg_a_sel,
  output logic [3:0]      reg_b_sel,
  output logic [7:0]      alu_op,
  output logic [3:0]      imm,
  output logic            flag_enable,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            busy
);

  localparam int unsigned IR_W   = 16;
  localparam int unsigned OP_W   = 8;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned NREG   = 16;

  localparam logic [OP_W-1:0] OP_CMP      = 8'h0A;
  localparam logic [OP_W-1:0] OP_CMPI     = 8'h0B;
  localparam logic [OP_W-1:0] OP_CMPU     = 8'h0C;
  localparam logic [OP_W-1:0] OP_NOP      = 8'h17;
  localparam logic [OP_W-1:0] OP_LAST     = 8'h17;
  localparam logic [OP_W-1:0] OP_FLAG_MAX = 8'h0C;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [IR_W-1:0]  ir_q, ir_d;
  logic [PC_W-1:0]  pc_d;
  logic             imem_req_d;
  logic [NREG-1:0]  reg_enable_d;
  logic [SEL_W-1:0] reg_a_sel_d, reg_b_sel_d, imm_d;
  logic [OP_W-1:0]  alu_op_d;
  logic             flag_enable_d, halted_d, busy_d;

  logic [OP_W-1:0]  ir_op_c;
  logic [SEL_W-1:0] ir_dst_c;
  logic             ir_writes_c;

  assign ir_op_c     = ir_q[15:8];
  assign ir_dst_c    = ir_q[7:4];
  // Compares and NOP only touch flags or nothing; no register write-back.
  assign ir_writes_c = !(ir_op_c inside {OP_CMP, OP_CMPI, OP_CMPU, OP_NOP});

  assign imem_addr = pc;

  // State and registered outputs.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      pc          <= '0;
      imem_req    <= 1'b0;
      reg_enable  <= '0;
      reg_a_sel   <= '0;
      reg_b_sel   <= '0;
      alu_op      <= OP_NOP;
      imm         <= '0;
      flag_enable <= 1'b0;
      halted      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      pc          <= pc_d;
      imem_req    <= imem_req_d;
      reg_enable  <= reg_enable_d;
      reg_a_sel   <= reg_a_sel_d;
      reg_b_sel   <= reg_b_sel_d;
      alu_op      <= alu_op_d;
      imm         <= imm_d;
      flag_enable <= flag_enable_d;
      halted      <= halted_d;
      busy        <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    pc_d          = pc;
    reg_a_sel_d   = reg_a_sel;
    reg_b_sel_d   = reg_b_sel;
    alu_op_d      = alu_op;
    imm_d         = imm;
    reg_enable_d  = '0;
    flag_enable_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end

      S_FETCH: begin
        if (imem_valid) begin
          ir_d        = imem_data;
          // Controls are presented during DECODE so the read muxes and ALU
          // settle before the write-enable pulse in EXEC.
          alu_op_d    = imem_data[15:8];
          reg_a_sel_d = imem_data[7:4];
          reg_b_sel_d = imem_data[3:0];
          imm_d       = imem_data[3:0];
          state_d     = S_DECODE;
        end
      end

      S_DECODE: begin
        alu_op_d    = ir_q[15:8];
        reg_a_sel_d = ir_q[7:4];
        reg_b_sel_d = ir_q[3:0];
        imm_d       = ir_q[3:0];
        if (ir_op_c > OP_LAST) begin
          state_d = S_HALT;
        end else begin
          state_d       = S_EXEC;
          reg_enable_d  = ir_writes_c ? (NREG'(1) << ir_dst_c) : '0;
          flag_enable_d = (ir_op_c <= OP_FLAG_MAX);
        end
      end

      S_EXEC: begin
        pc_d    = pc + PC_W'(1);
        state_d = run ? S_FETCH : S_IDLE;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    imem_req_d = (state_d == S_FETCH);
    busy_d     = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_EXEC);
    halted_d   = (state_d == S_HALT);
  end

endmodule

// File: tb/tb_instr_decode_seq.sv
// Directed bench for instr_decode_seq: inputs change and outputs are sampled
// on the falling edge; the DUT updates on the rising edge.
module tb_instr_decode_seq;

  localparam int unsigned PC_W = 8;

  logic            clock;
  logic            Reset;
  logic            run;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_valid;
  logic [15:0]     imem_data;
  logic [15:0]     reg_enable;
  logic [3:0]      reg_a_sel;
  logic [3:0]      reg_b_sel;
  logic [7:0]      alu_op;
  logic [3:0]      imm;
  logic            flag_enable;
  logic [PC_W-1:0] pc;
  logic            halted;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  instr_decode_seq #(.PC_W(PC_W)) dut (
    .clock       (clock),
    .Reset       (Reset),
    .run         (run),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_data   (imem_data),
    .reg_enable  (reg_enable),
    .reg_a_sel   (reg_a_sel),
    .reg_b_sel   (reg_b_sel),
    .alu_op      (alu_op),
    .imm         (imm),
    .flag_enable (flag_enable),
    .pc          (pc),
    .halted      (halted),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".imem_req"},    32'(imem_req),    32'h0);
    chk({tag, ".reg_enable"},  32'(reg_enable),  32'h0);
    chk({tag, ".alu_op"},      32'(alu_op),      32'h17);
    chk({tag, ".reg_a_sel"},   32'(reg_a_sel),   32'h0);
    chk({tag, ".reg_b_sel"},   32'(reg_b_sel),   32'h0);
    chk({tag, ".imm"},         32'(imm),         32'h0);
    chk({tag, ".flag_enable"}, 32'(flag_enable), 32'h0);
    chk({tag, ".pc"},          32'(pc),          32'h0);
    chk({tag, ".halted"},      32'(halted),      32'h0);
    chk({tag, ".busy"},        32'(busy),        32'h0);
  endtask

  // Entered at a falling edge in FETCH; holds valid low for 'delay' cycles,
  // then returns the word. Leaves at the falling edge inside DECODE.
  task automatic fetch_word(input logic [15:0] word, input int delay, input logic [PC_W-1:0] exp_addr);
    for (int i = 0; i < delay; i++) begin
      chk("stall.imem_req",    32'(imem_req),    32'h1);
      chk("stall.imem_addr",   32'(imem_addr),   32'(exp_addr));
      chk("stall.reg_enable",  32'(reg_enable),  32'h0);
      chk("stall.flag_enable", 32'(flag_enable), 32'h0);
      @(negedge clock);
    end
    chk("fetch.imem_req",  32'(imem_req),  32'h1);
    chk("fetch.imem_addr", 32'(imem_addr), 32'(exp_addr));
    imem_valid = 1'b1;
    imem_data  = word;
    @(negedge clock);
    imem_valid = 1'b0;
    imem_data  = 16'hDEAD;
    chk("decode.imem_req",   32'(imem_req),   32'h0);
    chk("decode.reg_enable", 32'(reg_enable), 32'h0);
  endtask

  // Runs one NOP at the current pc, ending at the falling edge in the next FETCH.
  task automatic do_nop(input logic [PC_W-1:0] exp_addr);
    fetch_word(16'h1700, 0, exp_addr);
    @(negedge clock);
    @(negedge clock);
  endtask

  initial begin
    Reset      = 1'b0;
    run        = 1'b0;
    imem_valid = 1'b0;
    imem_data  = 16'h0000;
    repeat (2) @(negedge clock);
    chk_reset_vals("reset");

    // Start fetching, then reset in the middle of the fetch.
    Reset = 1'b1;
    run   = 1'b1;
    @(negedge clock);
    chk("fetch0.imem_req",  32'(imem_req),  32'h1);
    chk("fetch0.imem_addr", 32'(imem_addr), 32'h0);
    chk("fetch0.busy",      32'(busy),      32'h1);
    #2 Reset = 1'b0;
    #1 chk_reset_vals("midfetch_reset");
    imem_valid = 1'b1;
    imem_data  = 16'h0155;
    @(negedge clock);
    imem_valid = 1'b0;
    chk("in_reset.imem_req", 32'(imem_req), 32'h0);
    Reset = 1'b1;
    @(negedge clock);

    // 0x0132 returned on the first request cycle.
    fetch_word(16'h0132, 0, 8'd0);
    chk("i0.dec.alu_op",    32'(alu_op),    32'h01);
    chk("i0.dec.reg_a_sel", 32'(reg_a_sel), 32'h3);
    chk("i0.dec.reg_b_sel", 32'(reg_b_sel), 32'h2);
    chk("i0.dec.imm",       32'(imm),       32'h2);
    chk("i0.dec.flag",      32'(flag_enable), 32'h0);
    @(negedge clock);
    chk("i0.exe.reg_enable", 32'(reg_enable),  32'h0008);
    chk("i0.exe.flag",       32'(flag_enable), 32'h1);
    chk("i0.exe.alu_op",     32'(alu_op),      32'h01);
    chk("i0.exe.pc",         32'(pc),          32'h0);
    @(negedge clock);
    chk("i0.post.reg_enable", 32'(reg_enable),  32'h0);
    chk("i0.post.flag",       32'(flag_enable), 32'h0);
    chk("i0.post.pc",         32'(pc),          32'h1);

    // CMP R4,R5: flags only, no write.
    fetch_word(16'h0A45, 0, 8'd1);
    chk("cmp.dec.reg_a_sel", 32'(reg_a_sel), 32'h4);
    chk("cmp.dec.reg_b_sel", 32'(reg_b_sel), 32'h5);
    @(negedge clock);
    chk("cmp.exe.reg_enable", 32'(reg_enable),  32'h0);
    chk("cmp.exe.flag",       32'(flag_enable), 32'h1);
    @(negedge clock);
    chk("cmp.post.pc", 32'(pc), 32'h2);

    // Five-cycle fetch latency: request held for six cycles.
    fetch_word(16'h0512, 5, 8'd2);
    @(negedge clock);
    chk("slow.exe.reg_enable", 32'(reg_enable),  32'h0002);
    chk("slow.exe.flag",       32'(flag_enable), 32'h1);
    @(negedge clock);

    // NOP: no enables.
    fetch_word(16'h1700, 0, 8'd3);
    @(negedge clock);
    chk("nop.exe.reg_enable", 32'(reg_enable),  32'h0);
    chk("nop.exe.flag",       32'(flag_enable), 32'h0);
    @(negedge clock);

    // Opcode 0x10 writes R15 but does not touch flags.
    fetch_word(16'h10F0, 0, 8'd4);
    @(negedge clock);
    chk("op10.exe.reg_enable", 32'(reg_enable),  32'h8000);
    chk("op10.exe.flag",       32'(flag_enable), 32'h0);
    @(negedge clock);

    // run dropped mid-fetch: instruction completes, then IDLE.
    run = 1'b0;
    fetch_word(16'h0211, 0, 8'd5);
    @(negedge clock);
    chk("stop.exe.reg_enable", 32'(reg_enable), 32'h0002);
    @(negedge clock);
    chk("stop.idle.imem_req", 32'(imem_req), 32'h0);
    chk("stop.idle.busy",     32'(busy),     32'h0);
    chk("stop.idle.pc",       32'(pc),       32'h6);
    repeat (2) @(negedge clock);
    chk("stop.idle2.imem_req", 32'(imem_req), 32'h0);

    // Run NOPs up to pc=255, then check the wrap.
    run = 1'b1;
    @(negedge clock);
    for (int a = 6; a < 255; a++) do_nop(PC_W'(a));
    chk("wrap.pre.pc", 32'(pc), 32'd255);
    fetch_word(16'h0300, 0, 8'd255);
    @(negedge clock);
    chk("wrap.exe.reg_enable", 32'(reg_enable), 32'h0001);
    @(negedge clock);
    chk("wrap.post.pc",        32'(pc),        32'h0);
    chk("wrap.post.imem_addr", 32'(imem_addr), 32'h0);

    // Illegal opcode at pc=7 halts.
    for (int a = 0; a < 7; a++) do_nop(PC_W'(a));
    fetch_word(16'h2000, 0, 8'd7);
    chk("halt.dec.alu_op", 32'(alu_op), 32'h20);
    @(negedge clock);
    chk("halt.halted",     32'(halted),      32'h1);
    chk("halt.busy",       32'(busy),        32'h0);
    chk("halt.pc",         32'(pc),          32'h7);
    chk("halt.reg_enable", 32'(reg_enable),  32'h0);
    chk("halt.flag",       32'(flag_enable), 32'h0);
    chk("halt.imem_req",   32'(imem_req),    32'h0);
    for (int i = 0; i < 4; i++) begin
      run        = ~run;
      imem_valid = 1'b1;
      imem_data  = 16'h0132;
      @(negedge clock);
      chk("halt.stay.halted",     32'(halted),     32'h1);
      chk("halt.stay.pc",         32'(pc),         32'h7);
      chk("halt.stay.reg_enable", 32'(reg_enable), 32'h0);
      chk("halt.stay.imem_req",   32'(imem_req),   32'h0);
    end
    imem_valid = 1'b0;
    #2 Reset = 1'b0;
    #1 chk_reset_vals("halt_reset");
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
